branch_ctrl: RTL and testbench

- Sequences branch/jump resolution in EX: accepts one control-transfer op at a time and drives the bu operands.
- Computes the target, detects mispredicts and issues the PC redirect plus pipeline flush.
- Maintains a 2-bit branch history table (BHT) that IF reads for prediction.
- Sits between the ID/EX register, the bu instance and the IF PC mux.

---
 rtl/branch_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_branch_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Branch/jump resolution in EX: resolves one control-transfer op, redirects and flushes on mispredict.
// Optional branch history table enabled by COTM32_BPRED_EN; accept N, done N+1, redirect N+2.
package branch_ctrl_pkg;
  localparam logic [2:0] BU_EQ  = 3'd0;
  localparam logic [2:0] BU_NE  = 3'd1;
  localparam logic [2:0] BU_LT  = 3'd2;
  localparam logic [2:0] BU_GE  = 3'd3;
  localparam logic [2:0] BU_LTU = 3'd4;
  localparam logic [2:0] BU_GEU = 3'd5;
endpackage

module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int BHT_ENTRIES  = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_kind,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_imm,
  input  logic            i_pred_taken,
  input  logic [XLEN-1:0] i_pred_target,
  output logic [XLEN-1:0] o_bu_a,
  output logic [XLEN-1:0] o_bu_b,
  output logic [2:0]      o_bu_op,
  input  logic            i_bu_take,
  input  logic            i_kill,
  output logic            o_done,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_flush,
  output logic            o_misalign,
  output logic [XLEN-1:0] o_bad_pc,
  input  logic [XLEN-1:0] i_if_pc,
  output logic            o_if_pred_taken
);

  localparam logic [1:0] K_BR   = 2'b00;
  localparam logic [1:0] K_JAL  = 2'b01;
  localparam logic [1:0] K_JALR = 2'b10;
  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_REDIR, S_FLUSH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q, pred_target_q;
  logic [1:0]      kind_q;
  logic [2:0]      op_q;
  logic            pred_taken_q;
  logic            latch_en;
  logic            bht_we;

  logic            taken;
  logic            mis_tgt;
  logic            mispred;
  logic [XLEN-1:0] target, seq_pc, actual, predicted;

  always_comb begin
    taken = 1'b0;
    case (kind_q)
      K_BR:          taken = i_bu_take;
      K_JAL, K_JALR: taken = 1'b1;
      default:       taken = 1'b0;
    endcase
    target    = (kind_q == K_JALR) ? ((rs1_q + imm_q) & ~XLEN'(1)) : (pc_q + imm_q);
    seq_pc    = pc_q + XLEN'(4);
    actual    = taken ? target : seq_pc;
    predicted = pred_taken_q ? pred_target_q : seq_pc;
    mis_tgt   = taken && target[1];
    mispred   = (actual != predicted);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    redir_pc_d = redir_pc_q;
    latch_en   = 1'b0;
    bht_we     = 1'b0;
    o_done     = 1'b0;
    o_misalign = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_valid && !i_kill) begin
          latch_en = 1'b1;
          state_d  = S_EVAL;
        end
      end
      S_EVAL: begin
        if (i_kill) begin
          state_d = S_IDLE;
        end else begin
          o_done = 1'b1;
          // A misaligned taken target traps, so it must not train the predictor.
          bht_we = (kind_q == K_BR) && !mis_tgt;
          if (mis_tgt) begin
            o_misalign = 1'b1;
            state_d    = S_IDLE;
          end else if (mispred) begin
            redir_pc_d = actual;
            state_d    = S_REDIR;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_REDIR: begin
        if (i_kill || FLUSH_CYCLES <= 1) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = CW'(FLUSH_CYCLES - 1);
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (i_kill || cnt_q <= CW'(1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      imm_q         <= '0;
      kind_q        <= 2'b11;
      op_q          <= BU_EQ;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else if (latch_en) begin
      pc_q          <= i_pc;
      rs1_q         <= i_rs1;
      rs2_q         <= i_rs2;
      imm_q         <= i_imm;
      kind_q        <= i_kind;
      op_q          <= i_op;
      pred_taken_q  <= i_pred_taken;
      pred_target_q <= i_pred_target;
    end
  end

  assign o_ready       = (state_q == S_IDLE);
  assign o_redirect    = (state_q == S_REDIR) && !i_kill;
  assign o_redirect_pc = o_redirect ? redir_pc_q : '0;
  assign o_flush       = (state_q == S_REDIR) || (state_q == S_FLUSH);
  assign o_bad_pc      = o_misalign ? target : '0;
  assign o_bu_a        = rs1_q;
  assign o_bu_b        = rs2_q;
  assign o_bu_op       = op_q;

`ifdef COTM32_BPRED_EN
  localparam int IW = $clog2(BHT_ENTRIES);

  logic [1:0]    bht_q [BHT_ENTRIES];
  logic [IW-1:0] upd_idx, rd_idx;

  assign upd_idx = pc_q[IW+1:2];
  assign rd_idx  = i_if_pc[IW+1:2];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (bht_we) begin
      if (taken && bht_q[upd_idx] != 2'b11) bht_q[upd_idx] <= bht_q[upd_idx] + 2'd1;
      else if (!taken && bht_q[upd_idx] != 2'b00) bht_q[upd_idx] <= bht_q[upd_idx] - 2'd1;
    end
  end

  // Read before the clocked update, so a same-cycle write shows the old counter.
  assign o_if_pred_taken = bht_q[rd_idx][1];
`else
  assign o_if_pred_taken = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{i_if_pc, bht_we, (BHT_ENTRIES > 1)};

endmodule

// File: tb/tb_branch_ctrl.sv
// Randomized + directed bench for branch_ctrl against a behavioural resolution/BHT model.
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;

  localparam int XLEN = 32;
  localparam int BHT_ENTRIES = 64;
  localparam int FLUSH_CYCLES = 2;

  logic            i_clk, i_rst_n, i_valid, o_ready;
  logic [1:0]      i_kind;
  logic [2:0]      i_op, o_bu_op;
  logic [31:0]     i_pc, i_rs1, i_rs2, i_imm, i_pred_target;
  logic            i_pred_taken, i_bu_take, i_kill;
  logic [31:0]     o_bu_a, o_bu_b, o_redirect_pc, o_bad_pc, i_if_pc;
  logic            o_done, o_redirect, o_flush, o_misalign, o_if_pred_taken;

  int vectors = 0;
  int miscompares = 0;
  int bht_m [BHT_ENTRIES];

  branch_ctrl #(.XLEN(XLEN), .BHT_ENTRIES(BHT_ENTRIES), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_kind(i_kind), .i_op(i_op), .i_pc(i_pc), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_imm(i_imm), .i_pred_taken(i_pred_taken), .i_pred_target(i_pred_target),
    .o_bu_a(o_bu_a), .o_bu_b(o_bu_b), .o_bu_op(o_bu_op), .i_bu_take(i_bu_take),
    .i_kill(i_kill), .o_done(o_done), .o_redirect(o_redirect),
    .o_redirect_pc(o_redirect_pc), .o_flush(o_flush), .o_misalign(o_misalign),
    .o_bad_pc(o_bad_pc), .i_if_pc(i_if_pc), .o_if_pred_taken(o_if_pred_taken)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic bu_eval(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      BU_EQ:   return a == b;
      BU_NE:   return a != b;
      BU_LT:   return $signed(a) < $signed(b);
      BU_GE:   return $signed(a) >= $signed(b);
      BU_LTU:  return a < b;
      BU_GEU:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Environment: the branch unit compares whatever operands the controller drives.
  always_comb i_bu_take = bu_eval(o_bu_op, o_bu_a, o_bu_b);

  function automatic int bidx(input logic [31:0] pc);
    return int'((pc >> 2) % BHT_ENTRIES);
  endfunction

  function automatic logic exp_pred(input logic [31:0] pc);
`ifdef COTM32_BPRED_EN
    return bht_m[bidx(pc)] >= 2;
`else
    return (pc === 32'hx);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [1:0] kind, input logic [2:0] op, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                       input logic pt, input logic [31:0] ptgt,
                       output logic tk, output logic [31:0] tgt, output logic mis,
                       output logic redir, output logic [31:0] act);
    logic [31:0] pred;
    case (kind)
      2'b00:   tk = bu_eval(op, rs1, rs2);
      2'b01,
      2'b10:   tk = 1'b1;
      default: tk = 1'b0;
    endcase
    tgt   = (kind == 2'b10) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
    act   = tk ? tgt : pc + 32'd4;
    pred  = pt ? ptgt : pc + 32'd4;
    mis   = tk && tgt[1];
    redir = !mis && (act != pred);
  endtask

  task automatic drive(input logic [1:0] kind, input logic [2:0] op, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                       input logic pt, input logic [31:0] ptgt);
    i_kind = kind; i_op = op; i_pc = pc; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm;
    i_pred_taken = pt; i_pred_target = ptgt; i_valid = 1'b1;
  endtask

  task automatic run_op(input logic [1:0] kind, input logic [2:0] op, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic pt, input logic [31:0] ptgt, input logic kill);
    logic tk, mis, redir;
    logic [31:0] tgt, act;
    model(kind, op, pc, rs1, rs2, imm, pt, ptgt, tk, tgt, mis, redir, act);
    @(negedge i_clk);
    check("ready_idle", o_ready, 1);
    drive(kind, op, pc, rs1, rs2, imm, pt, ptgt);
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0; i_kill = kill; i_if_pc = pc;
    #1;
    check("bu_a", o_bu_a, rs1);
    check("bu_b", o_bu_b, rs2);
    check("bu_op", o_bu_op, op);
    check("done", o_done, !kill);
    check("misalign", o_misalign, !kill && mis);
    if (!kill && mis) check("bad_pc", o_bad_pc, tgt);
    check("redirect_eval", o_redirect, 0);
    check("ready_eval", o_ready, 0);
    check("if_pred_eval", o_if_pred_taken, exp_pred(pc));
    if (!kill && kind == 2'b00 && !mis)
      bht_m[bidx(pc)] = tk ? ((bht_m[bidx(pc)] < 3) ? bht_m[bidx(pc)] + 1 : 3)
                           : ((bht_m[bidx(pc)] > 0) ? bht_m[bidx(pc)] - 1 : 0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_kill = 1'b0;
    #1;
    if (!kill && redir) begin
      check("redirect", o_redirect, 1);
      check("redirect_pc", o_redirect_pc, act);
      check("flush_redir", o_flush, 1);
      check("ready_redir", o_ready, 0);
      for (int k = 1; k < FLUSH_CYCLES; k++) begin
        @(negedge i_clk);
        #1;
        check("flush_hold", o_flush, 1);
        check("redirect_hold", o_redirect, 0);
        check("ready_flush", o_ready, 0);
      end
      @(negedge i_clk);
      #1;
    end
    check("ready_after", o_ready, 1);
    check("flush_after", o_flush, 0);
    check("redirect_after", o_redirect, 0);
    check("done_after", o_done, 0);
    check("if_pred_after", o_if_pred_taken, exp_pred(pc));
  endtask

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_kind = 2'b11; i_op = BU_EQ; i_pc = '0; i_rs1 = '0;
    i_rs2 = '0; i_imm = '0; i_pred_taken = 1'b0; i_pred_target = '0; i_kill = 1'b0; i_if_pc = '0;
    for (int i = 0; i < BHT_ENTRIES; i++) bht_m[i] = 1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_if_pc = 32'h100;
    #1;
    check("rst_ready", o_ready, 1);
    check("rst_done", o_done, 0);
    check("rst_redirect", o_redirect, 0);
    check("rst_flush", o_flush, 0);
    check("rst_misalign", o_misalign, 0);
    check("rst_redirect_pc", o_redirect_pc, 0);
    check("rst_bad_pc", o_bad_pc, 0);
    check("rst_bu_a", o_bu_a, 0);
    check("rst_bu_b", o_bu_b, 0);
    check("rst_bu_op", o_bu_op, BU_EQ);
    check("rst_if_pred", o_if_pred_taken, 0);

    run_op(2'b00, BU_EQ, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 32'h0, 1'b0);
    run_op(2'b00, BU_LT, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 32'h240, 1'b0);
    run_op(2'b10, BU_EQ, 32'h300, 32'h203, 32'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    run_op(2'b00, BU_EQ, 32'h304, 32'd7, 32'd7, 32'h10, 1'b0, 32'h0, 1'b1);
    run_op(2'b11, BU_EQ, 32'h400, 32'd0, 32'd0, 32'h0, 1'b1, 32'h999C, 1'b0);
    run_op(2'b11, BU_EQ, 32'h404, 32'd0, 32'd0, 32'h0, 1'b1, 32'h408, 1'b0);
    run_op(2'b01, BU_EQ, 32'h500, 32'd0, 32'd0, 32'h1000, 1'b0, 32'h0, 1'b0);
    run_op(2'b00, BU_NE, 32'h600, 32'd1, 32'd2, 32'h22, 1'b0, 32'h0, 1'b0);

    // Kill while idle must block acceptance.
    @(negedge i_clk);
    drive(2'b01, BU_EQ, 32'h700, 32'd0, 32'd0, 32'h80, 1'b0, 32'h0);
    i_kill = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0; i_kill = 1'b0;
    #1;
    check("kill_idle_ready", o_ready, 1);
    check("kill_idle_done", o_done, 0);

    // Kill during the redirect cycle suppresses the redirect and returns to idle.
    @(negedge i_clk);
    drive(2'b01, BU_EQ, 32'h800, 32'd0, 32'd0, 32'h40, 1'b0, 32'h0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    i_kill = 1'b1;
    #1;
    check("kill_redir_redirect", o_redirect, 0);
    @(negedge i_clk);
    i_kill = 1'b0;
    #1;
    check("kill_redir_ready", o_ready, 1);
    check("kill_redir_flush", o_flush, 0);

    // Async reset during the flush tail.
    @(negedge i_clk);
    drive(2'b01, BU_EQ, 32'h900, 32'd0, 32'd0, 32'h40, 1'b0, 32'h0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    check("flush_before_rst", o_flush, 1);
    i_rst_n = 1'b0;
    #1;
    check("rst_async_flush", o_flush, 0);
    check("rst_async_ready", o_ready, 1);
    for (int i = 0; i < BHT_ENTRIES; i++) bht_m[i] = 1;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_if_pc = 32'h100;
    #1;
    check("rst_bht_100", o_if_pred_taken, exp_pred(32'h100));
    i_if_pc = 32'h200;
    #1;
    check("rst_bht_200", o_if_pred_taken, exp_pred(32'h200));

    for (int n = 0; n < 60; n++) begin
      logic [1:0] kind;
      logic [2:0] op;
      logic [31:0] pc, rs1, rs2, imm, ptgt;
      logic pt, kill;
      int r;
      logic [31:0] vals [5];
      vals[0] = 32'd0; vals[1] = 32'd1; vals[2] = 32'hFFFF_FFFF;
      vals[3] = 32'd5; vals[4] = 32'h8000_0000;
      kind = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) kind = 2'b00;
      op   = 3'($urandom_range(0, 5));
      pc   = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
      rs1  = vals[$urandom_range(0, 4)];
      rs2  = vals[$urandom_range(0, 4)];
      r    = int'($urandom_range(0, 63));
      imm  = (r % 4 == 0) ? 32'((r - 32) * 2) : 32'((r - 32) * 4);
      pt   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       ptgt = (kind == 2'b10) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
        1:       ptgt = pc + 32'd4;
        default: ptgt = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      endcase
      kill = ($urandom_range(0, 7) == 0);
      run_op(kind, op, pc, rs1, rs2, imm, pt, ptgt, kill);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
